// File: rtl/vram_arbiter.sv
// Shares one 32Kx8 VRAM between fixed slot-0 video reads and queued CPU writes.
// Define VRAM_WR_COALESCE_EN to merge a write into the FIFO tail when addresses match.
module vram_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int LVL_W      = 3
) (
  input  logic             pixClock,
  input  logic             reset,
  input  logic [9:0]       hCount,
  input  logic [14:0]      vidAddr,
  input  logic             nVidOE,
  input  logic             wrValid,
  input  logic [14:0]      wrAddr,
  input  logic [7:0]       wrData,
  output logic             wrReady,
  output logic [14:0]      vramAddr,
  output logic [7:0]       vramDout,
  output logic             vramDoutEn,
  output logic             nvramOE,
  output logic             nvramWE,
  output logic [LVL_W-1:0] wrLevel,
  output logic             wrOverflow
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [14:0] addr;
    logic [7:0]  data;
  } wr_ent_t;

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t          state;
  wr_ent_t         fifo [FIFO_DEPTH];
  logic [AW-1:0]   rd_idx, wr_idx;
  logic [LVL_W-1:0] level;
  logic [14:0]     wr_addr_q;
  logic            empty, full, in_window, pop, tail_hit, push;
  logic            unused_hcount;

  assign unused_hcount = ^hCount[9:3];
  assign empty     = (level == '0);
  assign full      = (level == LVL_W'(FIFO_DEPTH));
  // Starting no later than slot 4 keeps HOLD inside slot 7, clear of the slot-0 read.
  assign in_window = (hCount[2:0] <= 3'd4);
  assign pop       = (state == IDLE) && !empty && in_window;

`ifdef VRAM_WR_COALESCE_EN
  logic [AW-1:0] tail_idx;
  assign tail_idx = wr_idx - 1'b1;
  // A tail that is also the head leaving this cycle cannot be merged into.
  assign tail_hit = !empty && (fifo[tail_idx].addr == wrAddr) &&
                    !(pop && level == LVL_W'(1));
`else
  assign tail_hit = 1'b0;
`endif

  assign wrReady  = !full || tail_hit;
  assign push     = wrValid && !full && !tail_hit;
  assign wrLevel  = level;
  assign vramAddr = (state == IDLE) ? vidAddr : wr_addr_q;
  assign nvramOE  = (state == IDLE) ? nVidOE : 1'b1;

  always_ff @(posedge pixClock) begin
    if (push) fifo[wr_idx] <= '{addr: wrAddr, data: wrData};
`ifdef VRAM_WR_COALESCE_EN
    if (wrValid && tail_hit) fifo[tail_idx].data <= wrData;
`endif
  end

  always_ff @(posedge pixClock or posedge reset) begin
    if (reset) begin
      rd_idx     <= '0;
      wr_idx     <= '0;
      level      <= '0;
      wrOverflow <= 1'b0;
    end else begin
      if (push) wr_idx <= wr_idx + 1'b1;
      if (pop)  rd_idx <= rd_idx + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (wrValid && !wrReady) wrOverflow <= 1'b1;
    end
  end

  always_ff @(posedge pixClock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      wr_addr_q  <= '0;
      vramDout   <= '0;
      vramDoutEn <= 1'b0;
      nvramWE    <= 1'b1;
    end else begin
      case (state)
        IDLE: if (pop) begin
          state      <= SETUP;
          wr_addr_q  <= fifo[rd_idx].addr;
          vramDout   <= fifo[rd_idx].data;
          vramDoutEn <= 1'b1;
          nvramWE    <= 1'b1;
        end
        SETUP: begin
          state   <= STROBE;
          nvramWE <= 1'b0;
        end
        STROBE: begin
          state   <= HOLD;
          nvramWE <= 1'b1;
        end
        HOLD: begin
          state      <= IDLE;
          vramDoutEn <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed slot/overflow/reset cases plus random traffic
// checked cycle by cycle against a queue-based reference and a VRAM image.
module tb_vram_arbiter;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [14:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic        pixClock = 1'b0;
  logic        reset;
  logic [9:0]  hCount;
  logic [14:0] vidAddr, wrAddr, vramAddr;
  logic        nVidOE, wrValid, wrReady, vramDoutEn, nvramOE, nvramWE, wrOverflow;
  logic [7:0]  wrData, vramDout;
  logic [2:0]  wrLevel;

  vram_arbiter #(.FIFO_DEPTH(DEPTH), .LVL_W(3)) dut (
    .pixClock(pixClock), .reset(reset), .hCount(hCount), .vidAddr(vidAddr),
    .nVidOE(nVidOE), .wrValid(wrValid), .wrAddr(wrAddr), .wrData(wrData),
    .wrReady(wrReady), .vramAddr(vramAddr), .vramDout(vramDout),
    .vramDoutEn(vramDoutEn), .nvramOE(nvramOE), .nvramWE(nvramWE),
    .wrLevel(wrLevel), .wrOverflow(wrOverflow)
  );

  always #5 pixClock = ~pixClock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference: pending queue, write phase (0 idle, 1..3 setup/strobe/hold)
  wr_t         q[$];
  int          m_phase;
  wr_t         m_cur;
  logic        m_ovf;
  logic [9:0]  hc, vc;
  logic        s_we, s_en, s_oe, s_ready, s_ovf;
  logic [2:0]  s_level;
  logic [14:0] s_addr;
  logic [7:0]  s_dout;
  logic [7:0]  mem_exp [0:32767];
  logic [7:0]  mem_dut [0:32767];
  logic [7:0]  wr_log[$];
  logic [9:0]  we_hc[$];

  task automatic model_reset();
    q.delete();
    m_phase = 0;
    m_cur   = '0;
    m_ovf   = 1'b0;
  endtask

  task automatic step(input logic v, input logic [14:0] a, input logic [7:0] d);
    int   sz;
    logic pop, hit, rdy;
    @(negedge pixClock);
    hCount  = hc;
    vidAddr = {vc[8:0], hc[8:3]};
    nVidOE  = !(hc[2:0] == 3'd0 && hc < 10'd640 && vc < 10'd480);
    wrValid = v;
    wrAddr  = a;
    wrData  = d;
    #1;
    s_we = nvramWE; s_en = vramDoutEn; s_oe = nvramOE; s_ready = wrReady;
    s_ovf = wrOverflow; s_level = wrLevel; s_addr = vramAddr; s_dout = vramDout;

    sz  = q.size();
    pop = (m_phase == 0) && (sz > 0) && (hc[2:0] <= 3'd4);
    hit = 1'b0;
`ifdef VRAM_WR_COALESCE_EN
    if (sz > 0) hit = (q[sz-1].addr == a) && !(pop && sz == 1);
`endif
    rdy = (sz < DEPTH) || hit;

    chk("level", 32'(s_level), 32'(sz));
    chk("ready", 32'(s_ready), 32'(rdy));
    chk("we", 32'(s_we), 32'(m_phase != 2));
    chk("douten", 32'(s_en), 32'(m_phase != 0));
    chk("oe", 32'(s_oe), 32'((m_phase != 0) ? 1'b1 : nVidOE));
    chk("addr", 32'(s_addr), 32'((m_phase != 0) ? m_cur.addr : vidAddr));
    chk("dout", 32'(s_dout), 32'(m_cur.data));
    chk("ovf", 32'(s_ovf), 32'(m_ovf));
    chk("oe_en_excl", 32'(!s_oe && s_en), 32'(0));
    if (s_we === 1'b0) begin
      mem_dut[s_addr] = s_dout;
      wr_log.push_back(s_dout);
      we_hc.push_back(hc);
      chk("we_slot", 32'(hc[2:0] >= 3'd2 && hc[2:0] <= 3'd6), 32'(1));
    end

    if (v && hit) q[sz-1].data = d;
    if (pop) begin
      m_cur = q.pop_front();
      mem_exp[m_cur.addr] = m_cur.data;
      m_phase = 1;
    end else if (m_phase == 3) m_phase = 0;
    else if (m_phase > 0) m_phase++;
    if (v && !hit) begin
      if (rdy) q.push_back('{addr: a, data: d});
      else m_ovf = 1'b1;
    end

    @(posedge pixClock);
    if (hc == 10'd799) begin
      hc = 0;
      vc = (vc == 10'd524) ? 10'd0 : vc + 10'd1;
    end else hc = hc + 10'd1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 15'h0, 8'h0);
  endtask

  task automatic do_reset();
    @(negedge pixClock);
    reset = 1'b1;
    wrValid = 1'b0;
    #1;
    chk("rst_we", 32'(nvramWE), 32'(1));
    chk("rst_en", 32'(vramDoutEn), 32'(0));
    chk("rst_level", 32'(wrLevel), 32'(0));
    chk("rst_ovf", 32'(wrOverflow), 32'(0));
    chk("rst_dout", 32'(vramDout), 32'(0));
    model_reset();
    @(negedge pixClock);
    reset = 1'b0;
  endtask

  initial begin
    logic [9:0] ov_hc [6];
    reset = 1'b1; hCount = '0; vidAddr = '0; nVidOE = 1'b1;
    wrValid = 1'b0; wrAddr = '0; wrData = '0;
    hc = '0; vc = '0;
    model_reset();
    do_reset();

    // single write pushed at slot 5 waits for the next group
    hc = 10'h105;
    step(1'b1, 15'h1234, 8'hA5);
    idle(3);
    chk("single_idle_108", 32'(s_en), 32'(0));
    idle(1);
    chk("single_setup_en", 32'(s_en), 32'(1));
    chk("single_setup_we", 32'(s_we), 32'(1));
    chk("single_setup_addr", 32'(s_addr), 32'h1234);
    idle(1);
    chk("single_strobe_we", 32'(s_we), 32'(0));
    chk("single_strobe_dout", 32'(s_dout), 32'hA5);
    chk("single_strobe_addr", 32'(s_addr), 32'h1234);
    idle(1);
    chk("single_hold_we", 32'(s_we), 32'(1));
    chk("single_hold_en", 32'(s_en), 32'(1));
    idle(1);
    chk("single_done_en", 32'(s_en), 32'(0));

    // three back-to-back pushes from slot 7: strobes at slots 2, 6, then 2
    hc = 10'h117;
    we_hc.delete();
    step(1'b1, 15'h0200, 8'h01);
    step(1'b1, 15'h0201, 8'h02);
    step(1'b1, 15'h0202, 8'h03);
    idle(20);
    chk("burst_count", 32'(we_hc.size()), 32'(3));
    chk("burst_we0", (we_hc.size() > 0) ? 32'(we_hc[0]) : 32'hFFFF, 32'h11A);
    chk("burst_we1", (we_hc.size() > 1) ? 32'(we_hc[1]) : 32'hFFFF, 32'h11E);
    chk("burst_we2", (we_hc.size() > 2) ? 32'(we_hc[2]) : 32'hFFFF, 32'h122);

    // overflow: six pushes with no drain window
    do_reset();
    ov_hc = '{10'h105, 10'h106, 10'h107, 10'h10D, 10'h10E, 10'h10F};
    for (int i = 0; i < 6; i++) begin
      hc = ov_hc[i];
      step(1'b1, 15'h0300 + 15'(i), 8'(i + 16));
      if (i >= 4) chk("ovf_drop_ready", 32'(s_ready), 32'(0));
    end
    #1;
    chk("ovf_flag", 32'(wrOverflow), 32'(1));
    chk("ovf_level", 32'(wrLevel), 32'(4));

    // reset landing in STROBE with writes still queued
    for (int i = 0; i < 40 && m_phase != 2; i++) idle(1);
    #2;
    chk("pre_rst_we", 32'(nvramWE), 32'(0));
    reset = 1'b1;
    #1;
    chk("midrst_we", 32'(nvramWE), 32'(1));
    chk("midrst_en", 32'(vramDoutEn), 32'(0));
    model_reset();
    @(negedge pixClock);
    reset = 1'b0;
    #1;
    chk("midrst_level", 32'(wrLevel), 32'(0));
    chk("midrst_ovf", 32'(wrOverflow), 32'(0));

    // same address twice while not draining
    hc = 10'h105;
    wr_log.delete();
    step(1'b1, 15'h0010, 8'h11);
    step(1'b1, 15'h0010, 8'h22);
    #1;
`ifdef VRAM_WR_COALESCE_EN
    chk("coal_level", 32'(wrLevel), 32'(1));
    idle(20);
    chk("coal_writes", 32'(wr_log.size()), 32'(1));
    chk("coal_data", (wr_log.size() > 0) ? 32'(wr_log[0]) : 32'hFFFF, 32'h22);
`else
    chk("coal_level", 32'(wrLevel), 32'(2));
    idle(20);
    chk("coal_writes", 32'(wr_log.size()), 32'(2));
    chk("coal_data0", (wr_log.size() > 0) ? 32'(wr_log[0]) : 32'hFFFF, 32'h11);
    chk("coal_data1", (wr_log.size() > 1) ? 32'(wr_log[1]) : 32'hFFFF, 32'h22);
`endif

    // random traffic into a small address window
    for (int i = 0; i < 64; i++) begin
      mem_exp[i] = 8'h00;
      mem_dut[i] = 8'h00;
    end
    hc = '0;
    vc = '0;
    for (int i = 0; i < 20000; i++)
      step($urandom_range(0, 3) == 0, 15'($urandom_range(0, 63)), 8'($urandom));
    idle(40);
    for (int i = 0; i < 64; i++)
      chk($sformatf("mem[%0d]", i), 32'(mem_dut[i]), 32'(mem_exp[i]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
